hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It detects load-use hazards that forwarding cannot cover and inserts one bubble. It flushes wrong-path instructions on a taken branch resolved in EX. It sequences a fixed-latency multi-cycle multiply/divide unit by freezing IF/ID/EX until the operation completes. It sits beside the forwarding unit and drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/M.

## Interface
Parameters:
- MD_LAT, 4: total cycles a mult/div occupies EX; legal range 2..15.
- STALL_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_Rs  in  5  rs of the instruction in ID.
- ID_Rt  in  5  rt of the instruction in ID.
- ID_UsesRt  in  1  instruction in ID reads rt as a source.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_WR_out  in  5  destination register of the instruction in EX.
- EX_BranchTaken  in  1  branch/jump in EX resolved taken.
- EX_MulDiv  in  1  instruction in EX is mult/multu/div/divu.
- PCWrite  out  1  PC update enable.
- IF_IDWrite  out  1  IF/ID register write enable.
- IF_Flush  out  1  clear IF/ID to NOP.
- ID_Flush  out  1  load a bubble (all control 0) into ID/EX.
- EX_Hold  out  1  hold ID/EX contents; load a bubble into EX/M.
- MD_Start  out  1  one-cycle start pulse to the mult/div unit.
- MD_Busy  out  1  mult/div sequence in progress.
- StallCnt  out  STALL_W  count of cycles with PCWrite=0.

## Operation
- States:
  - RUN: normal operation.
  - MD_WAIT: mult/div in flight; 4-bit down-counter `cnt`.
- Load-use hazard (LU):
  - LU = EX_MemRead && EX_WR_out!=0 && (EX_WR_out==ID_Rs || (ID_UsesRt && EX_WR_out==ID_Rt)).
- Priority in RUN, highest first:
  1. EX_BranchTaken: IF_Flush=1, ID_Flush=1, PCWrite=1, IF_IDWrite=1. LU is ignored because the hazard instruction is on the wrong path.
  2. EX_MulDiv: MD_Start=1, EX_Hold=1, PCWrite=0, IF_IDWrite=0, cnt←MD_LAT-1, next state MD_WAIT.
  3. LU: PCWrite=0, IF_IDWrite=0, ID_Flush=1.
  4. Otherwise: PCWrite=1, IF_IDWrite=1, all flush/hold outputs 0.
- MD_WAIT:
  - MD_Busy=1; inputs ignored.
  - While cnt>1: PCWrite=0, IF_IDWrite=0, EX_Hold=1, cnt←cnt-1.
  - When cnt==1: release. PCWrite=1, IF_IDWrite=1, EX_Hold=0, next state RUN. The mult/div advances to M at the end of this cycle.
  - An LU condition present at release is evaluated in the next RUN cycle.
- StallCnt increments on every cycle with PCWrite=0 and saturates at all-ones.
- Decode outputs are combinational from state and inputs. State, cnt and StallCnt are registered.

## Timing
- While rst=1 (forced regardless of inputs):
  - PCWrite=1, IF_IDWrite=1.
  - IF_Flush=0, ID_Flush=0, EX_Hold=0, MD_Start=0, MD_Busy=0.
  - StallCnt=0, state=RUN, cnt=0.
- LU costs exactly 1 stall cycle; the following cycle the load is in M and forwarding covers the dependency.
- Mult/div entering EX at cycle t:
  - MD_Start=1 at t only.
  - Stall at t..t+MD_LAT-2, i.e. MD_LAT-1 stall cycles.
  - Release at t+MD_LAT-1.
  - MD_Busy high at t+1..t+MD_LAT-1.
- MD_LAT=2: single stall cycle at t; MD_WAIT is entered with cnt=1 and releases at t+1.
- Reset asserted mid-MD_WAIT: next cycle state=RUN and no MD_Start is issued. The mult/div unit is reset by the same rst.
- No back-to-back restart: a held mult/div stays in EX during MD_WAIT, and MD_Start is only decoded in RUN.

## Configuration
- HAZARD_MULDIV_EN defined: full mult/div sequencing as above.
- Not defined:
  - MD_WAIT and cnt are not built.
  - EX_MulDiv is ignored.
  - MD_Start, MD_Busy and EX_Hold are tied 0.
  - The port list is unchanged.

## Structure
- Shared package `hazard_pkg`:
  - state encoding (RUN=0, MD_WAIT=1).
  - NOP/bubble constant.
  - default MD_LAT.
- One sub-module, `md_seq`: the MD_WAIT FSM plus down-counter. Inputs: start, rst. Outputs: busy, hold, release. It is instantiated only under HAZARD_MULDIV_EN.
- Load-use detect, branch priority and StallCnt stay in `hazard_ctrl`.

## Test plan
- Load-use: EX lw, EX_WR_out=8; ID add with ID_Rs=8 → one cycle of PCWrite=0, IF_IDWrite=0, ID_Flush=1; next cycle all 1/0 normal; StallCnt=1.
- Zero/rt filter:
  - EX_WR_out=0 with ID_Rs=0 → no stall.
  - EX_WR_out=9, ID_Rt=9, ID_UsesRt=0 → no stall.
- Branch beats LU: EX_BranchTaken=1 with LU true in the same cycle → IF_Flush=1, ID_Flush=1, PCWrite=1, StallCnt unchanged.
- Mult/div, MD_LAT=4: EX_MulDiv=1 at t → MD_Start=1 at t only; EX_Hold=1 at t..t+2; MD_Busy=1 at t+1..t+3; release at t+3; StallCnt=3.
- Reset mid-sequence: rst=1 at t+1 of the mult/div case → next cycle RUN, all outputs at reset values, StallCnt=0.
- Saturation: STALL_W=4, 20 LU stall cycles → StallCnt holds 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: mult/div sequencer
// state encoding, default mult/div latency, pipeline-control bundles
// (including the bubble pattern) and the load-use detect helper.
package hazard_pkg;

    // Sequencer states
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } mdState_t;

    // Default number of cycles a mult/div occupies EX
    localparam int MD_LAT_DEFAULT = 4;

    // Width of the mult/div down-counter (MD_LAT up to 15)
    localparam int MD_CNT_W = 4;

    // One bundle of pipeline write-enable / flush controls
    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic ifFlush;
        logic idFlush;
        logic exHold;
        logic mdStart;
    } hazCtrl_t;

    // Free-running pipeline: everything advances, nothing flushed
    localparam hazCtrl_t CTRL_RUN = '{pcWrite: 1'b1, ifIdWrite: 1'b1, default: 1'b0};

    // Load-use bubble: freeze PC and IF/ID, inject a NOP into ID/EX
    localparam hazCtrl_t CTRL_BUBBLE = '{idFlush: 1'b1, default: 1'b0};

    // Taken branch: keep fetching from the target, squash IF and ID
    localparam hazCtrl_t CTRL_BRANCH = '{pcWrite: 1'b1, ifIdWrite: 1'b1,
                                         ifFlush: 1'b1, idFlush: 1'b1, default: 1'b0};

    // Mult/div in flight: freeze IF/ID/EX, bubble into EX/M
    localparam hazCtrl_t CTRL_FREEZE = '{exHold: 1'b1, default: 1'b0};

    // First cycle of a mult/div: freeze and pulse the unit's start
    localparam hazCtrl_t CTRL_MD_START = '{exHold: 1'b1, mdStart: 1'b1, default: 1'b0};

    // A load in EX whose result the instruction in ID needs right now
    function automatic logic isLoadUse(
        input logic       memRead,
        input logic [4:0] wr,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       usesRt
    );
        return memRead && (wr != 5'd0) && ((wr == rs) || (usesRt && (wr == rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Mult/div sequencer: tracks a multi-cycle operation held in EX with a
// down-counter, asserting hold until the final cycle and then release.
module md_seq
    import hazard_pkg::*;
#(
    parameter logic [MD_CNT_W-1:0] CNT_INIT = 4'd3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic hold,
    output logic releaseNow
);

    mdState_t              stateReg, stateNext;
    logic [MD_CNT_W-1:0]   cntReg, cntNext;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_RUN;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    // Next state: load the counter on start, count down, leave on the last cycle
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            ST_RUN: begin
                if (start) begin
                    stateNext = ST_MD_WAIT;
                    cntNext   = CNT_INIT;
                end
            end
            ST_MD_WAIT: begin
                if (cntReg > 4'd1) begin
                    cntNext = cntReg - 4'd1;
                end else begin
                    stateNext = ST_RUN;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = ST_RUN;
                cntNext   = '0;
            end
        endcase
    end

    // Outputs decoded from state and counter
    always_comb begin
        busy       = (stateReg == ST_MD_WAIT);
        hold       = (stateReg == ST_MD_WAIT) && (cntReg > 4'd1);
        releaseNow = (stateReg == ST_MD_WAIT) && (cntReg == 4'd1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use bubble, taken-
// branch flush, mult/div freeze and a saturating stall-cycle counter.
// Define HAZARD_MULDIV_EN to build mult/div sequencing; without it EX_MulDiv
// is ignored and MD_Start, MD_Busy and EX_Hold stay 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT  = MD_LAT_DEFAULT,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         ID_Rs,
    input  logic [4:0]         ID_Rt,
    input  logic               ID_UsesRt,
    input  logic               EX_MemRead,
    input  logic [4:0]         EX_WR_out,
    input  logic               EX_BranchTaken,
    input  logic               EX_MulDiv,
    output logic               PCWrite,
    output logic               IF_IDWrite,
    output logic               IF_Flush,
    output logic               ID_Flush,
    output logic               EX_Hold,
    output logic               MD_Start,
    output logic               MD_Busy,
    output logic [STALL_W-1:0] StallCnt
);

    // Counter value loaded on start: the start cycle itself is the first stall
    localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LAT - 1);

    logic               loadUse;
    logic               mdBusy;
    logic               mdHold;
    logic               mdRelease;
    logic               mdStartReq;
    hazCtrl_t           ctrl;
    logic [STALL_W-1:0] stallCntReg;

    assign loadUse = isLoadUse(EX_MemRead, EX_WR_out, ID_Rs, ID_Rt, ID_UsesRt);

`ifdef HAZARD_MULDIV_EN
    // A taken branch squashes the mult/div; a new start is only legal when idle
    assign mdStartReq = EX_MulDiv && !EX_BranchTaken && !mdBusy && !rst;

    md_seq #(
        .CNT_INIT   (MD_CNT_INIT)
    ) uMdSeq (
        .clk        (clk),
        .rst        (rst),
        .start      (mdStartReq),
        .busy       (mdBusy),
        .hold       (mdHold),
        .releaseNow (mdRelease)
    );
`else
    logic unusedMdCfg;

    assign mdStartReq  = 1'b0;
    assign mdBusy      = 1'b0;
    assign mdHold      = 1'b0;
    assign mdRelease   = 1'b0;
    assign unusedMdCfg = EX_MulDiv ^ (^MD_CNT_INIT);
`endif

    // Priority decode: reset, mult/div in flight, branch, mult/div start, load-use
    always_comb begin
        ctrl = CTRL_RUN;
        if (rst) begin
            ctrl = CTRL_RUN;
        end else if (mdBusy) begin
            if (mdHold) begin
                ctrl = CTRL_FREEZE;
            end else if (mdRelease) begin
                ctrl = CTRL_RUN;
            end
        end else if (EX_BranchTaken) begin
            ctrl = CTRL_BRANCH;
        end else if (mdStartReq) begin
            ctrl = CTRL_MD_START;
        end else if (loadUse) begin
            ctrl = CTRL_BUBBLE;
        end
    end

    assign PCWrite    = ctrl.pcWrite;
    assign IF_IDWrite = ctrl.ifIdWrite;
    assign IF_Flush   = ctrl.ifFlush;
    assign ID_Flush   = ctrl.idFlush;
    assign EX_Hold    = ctrl.exHold;
    assign MD_Start   = ctrl.mdStart;
    assign MD_Busy    = mdBusy && !rst;
    assign StallCnt   = stallCntReg;

    // Count every cycle the PC is frozen, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCntReg <= '0;
        end else if (!ctrl.pcWrite && (stallCntReg != '1)) begin
            stallCntReg <= stallCntReg + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a timeline model checked every cycle
// plus hand-computed spot checks. Works with or without HAZARD_MULDIV_EN.
module tb_hazard_ctrl;

    localparam int MD_LAT  = 4;
    localparam int STALL_W = 4;
    localparam int SAT     = (1 << STALL_W) - 1;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic [4:0]         ID_Rs;
    logic [4:0]         ID_Rt;
    logic               ID_UsesRt;
    logic               EX_MemRead;
    logic [4:0]         EX_WR_out;
    logic               EX_BranchTaken;
    logic               EX_MulDiv;
    logic               PCWrite;
    logic               IF_IDWrite;
    logic               IF_Flush;
    logic               ID_Flush;
    logic               EX_Hold;
    logic               MD_Start;
    logic               MD_Busy;
    logic [STALL_W-1:0] StallCnt;

    int nVec = 0;
    int nBad = 0;

    hazard_ctrl #(
        .MD_LAT         (MD_LAT),
        .STALL_W        (STALL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .EX_MemRead     (EX_MemRead),
        .EX_WR_out      (EX_WR_out),
        .EX_BranchTaken (EX_BranchTaken),
        .EX_MulDiv      (EX_MulDiv),
        .PCWrite        (PCWrite),
        .IF_IDWrite     (IF_IDWrite),
        .IF_Flush       (IF_Flush),
        .ID_Flush       (ID_Flush),
        .EX_Hold        (EX_Hold),
        .MD_Start       (MD_Start),
        .MD_Busy        (MD_Busy),
        .StallCnt       (StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge
    task automatic drive(input bit r, input int rs, input int rt, input bit uses,
                         input bit mr, input int wr, input bit br, input bit md);
        @(posedge clk);
        #1;
        rst            = r;
        ID_Rs          = 5'(rs);
        ID_Rt          = 5'(rt);
        ID_UsesRt      = uses;
        EX_MemRead     = mr;
        EX_WR_out      = 5'(wr);
        EX_BranchTaken = br;
        EX_MulDiv      = md;
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Mult/div tracked as a timeline: start cycle mdT, busy for the next
    // MD_LAT-1 cycles, frozen for all but the last of them.
    int cyc = 0;
    int mdT = 0;
    bit mdActive = 1'b0;
    int mStall = 0;
    int k;
    bit lu, ePc, eIfid, eIfF, eIdF, eHold, eStart, eBusy;

    always @(negedge clk) begin
        lu = EX_MemRead && (EX_WR_out != 0) &&
             ((EX_WR_out == ID_Rs) || (ID_UsesRt && (EX_WR_out == ID_Rt)));
        ePc = 1; eIfid = 1; eIfF = 0; eIdF = 0; eHold = 0; eStart = 0; eBusy = 0;
        k = cyc - mdT;
        if (rst) begin
            // reset values already set
        end else if (mdActive && k >= 1 && k <= MD_LAT - 1) begin
            eBusy = 1;
            if (k <= MD_LAT - 2) begin
                ePc = 0; eIfid = 0; eHold = 1;
            end
        end else if (EX_BranchTaken) begin
            eIfF = 1; eIdF = 1;
        end else if (MD_EN && EX_MulDiv) begin
            eStart = 1; eHold = 1; ePc = 0; eIfid = 0;
            mdT = cyc; mdActive = 1;
        end else if (lu) begin
            ePc = 0; eIfid = 0; eIdF = 1;
        end

        $display("cyc %0d rst=%0d lu=%0d br=%0d md=%0d | pcw=%0d ifw=%0d iff=%0d idf=%0d hold=%0d start=%0d busy=%0d cnt=%0d",
                 cyc, rst, lu, EX_BranchTaken, EX_MulDiv, PCWrite, IF_IDWrite,
                 IF_Flush, ID_Flush, EX_Hold, MD_Start, MD_Busy, StallCnt);

        chk($sformatf("c%0d PCWrite", cyc),    PCWrite,    ePc);
        chk($sformatf("c%0d IF_IDWrite", cyc), IF_IDWrite, eIfid);
        chk($sformatf("c%0d IF_Flush", cyc),   IF_Flush,   eIfF);
        chk($sformatf("c%0d ID_Flush", cyc),   ID_Flush,   eIdF);
        chk($sformatf("c%0d EX_Hold", cyc),    EX_Hold,    eHold);
        chk($sformatf("c%0d MD_Start", cyc),   MD_Start,   eStart);
        chk($sformatf("c%0d MD_Busy", cyc),    MD_Busy,    eBusy);
        chk($sformatf("c%0d StallCnt", cyc),   StallCnt,   mStall);

        if (rst) begin
            mStall   = 0;
            mdActive = 0;
        end else if (!ePc && mStall < SAT) begin
            mStall++;
        end
        if (mdActive && (cyc - mdT) >= MD_LAT - 1) mdActive = 0;
        cyc++;
    end

    // ---------------- directed stimulus with literal spot checks ----------------
    initial begin
        rst = 1; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_MemRead = 0;
        EX_WR_out = 0; EX_BranchTaken = 0; EX_MulDiv = 0;

        // Reset with hazard-looking inputs must still give reset values
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 8, 0, 0, 1, 8, 0, 0);
        chk("rst PCWrite", PCWrite, 1);
        chk("rst ID_Flush", ID_Flush, 0);
        chk("rst StallCnt", StallCnt, 0);

        // Load-use on rs: one bubble
        drive(0, 8, 0, 0, 1, 8, 0, 0);
        chk("lu PCWrite", PCWrite, 0);
        chk("lu ID_Flush", ID_Flush, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu+1 PCWrite", PCWrite, 1);
        chk("lu+1 StallCnt", StallCnt, 1);

        // $zero destination never stalls
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("zero PCWrite", PCWrite, 1);
        // rt match ignored when rt is not a source
        drive(0, 3, 9, 0, 1, 9, 0, 0);
        chk("rtoff PCWrite", PCWrite, 1);
        // rt match counts when rt is a source
        drive(0, 3, 9, 1, 1, 9, 0, 0);
        chk("rton PCWrite", PCWrite, 0);

        // Branch beats load-use
        drive(0, 7, 0, 0, 1, 7, 1, 0);
        chk("br IF_Flush", IF_Flush, 1);
        chk("br PCWrite", PCWrite, 1);
        chk("br StallCnt", StallCnt, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br+1 StallCnt", StallCnt, 2);

        // Mult/div at t, load-use inputs present during the wait
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("md t MD_Start", MD_Start, int'(MD_EN));
        chk("md t PCWrite", PCWrite, int'(!MD_EN));
        drive(0, 5, 0, 0, 1, 5, 0, 1);
        chk("md t+1 MD_Start", MD_Start, 0);
        chk("md t+1 MD_Busy", MD_Busy, int'(MD_EN));
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("md t+2 EX_Hold", EX_Hold, int'(MD_EN));
        drive(0, 5, 0, 0, 1, 5, 0, 1);
        chk("md t+3 PCWrite", PCWrite, MD_EN ? 1 : 0);
        chk("md t+3 EX_Hold", EX_Hold, 0);
        drive(0, 5, 0, 0, 1, 5, 0, 0);
        chk("md t+4 PCWrite", PCWrite, 0);
        chk("md t+4 StallCnt", StallCnt, MD_EN ? 5 : 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("md t+5 StallCnt", StallCnt, MD_EN ? 6 : 5);

        // Reset in the middle of a mult/div
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        chk("mdrst PCWrite", PCWrite, 1);
        chk("mdrst MD_Busy", MD_Busy, 0);
        chk("mdrst EX_Hold", EX_Hold, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mdrst+1 MD_Busy", MD_Busy, 0);
        chk("mdrst+1 MD_Start", MD_Start, 0);
        chk("mdrst+1 PCWrite", PCWrite, 1);
        chk("mdrst+1 StallCnt", StallCnt, 0);

        // 20 consecutive load-use stalls saturate a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(0, 6, 0, 0, 1, 6, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat StallCnt", StallCnt, 15);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

    // Safety net in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
